// File: rtl/seq_subtractor_64bit.sv
// rtl/seq_subtractor_64bit.sv - 64-bit subtractor, one 8-bit ripple-borrow slice per cycle; optional ovf output under SUB_OVERFLOW_EN
module seq_subtractor_64bit (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [63:0] a,
   input  logic [63:0] b,
   input  logic        bin,
   output logic [63:0] diff,
   output logic        bout,
   output logic        busy,
   output logic        done
`ifdef SUB_OVERFLOW_EN
   ,
   output logic        ovf
`endif
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state;
   logic [63:0] a_q;
   logic [63:0] b_q;
   logic [63:0] acc_q;
   logic [2:0]  idx_q;
   logic        br_q;

   logic [7:0]  slice_x;
   logic [7:0]  slice_y;
   logic [7:0]  slice_d;
   logic        slice_bout;
   logic        br_c;

   // Current slice: bitwise ripple-borrow chain seeded by the registered borrow
   always_comb begin
      slice_x    = a_q[{idx_q, 3'b000} +: 8];
      slice_y    = b_q[{idx_q, 3'b000} +: 8];
      slice_d    = 8'd0;
      br_c       = br_q;
      for (int i = 0; i < 8; i++) begin
         slice_d[i] = slice_x[i] ^ slice_y[i] ^ br_c;
         br_c       = (~slice_x[i] & slice_y[i]) | (~(slice_x[i] ^ slice_y[i]) & br_c);
      end
      slice_bout = br_c;
   end

   // Control FSM; diff/bout/ovf only change on the last slice so partial results never show
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         a_q   <= 64'd0;
         b_q   <= 64'd0;
         acc_q <= 64'd0;
         idx_q <= 3'd0;
         br_q  <= 1'b0;
         diff  <= 64'd0;
         bout  <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
`ifdef SUB_OVERFLOW_EN
         ovf   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  a_q   <= a;
                  b_q   <= b;
                  br_q  <= bin;
                  idx_q <= 3'd0;
                  acc_q <= 64'd0;
                  busy  <= 1'b1;
                  state <= RUN;
               end
            end
            RUN: begin
               acc_q[{idx_q, 3'b000} +: 8] <= slice_d;
               br_q                        <= slice_bout;
               if (idx_q == 3'd7) begin
                  diff  <= {slice_d, acc_q[55:0]};
                  bout  <= slice_bout;
`ifdef SUB_OVERFLOW_EN
                  // Signed overflow: operands differ in sign and result sign differs from a
                  ovf   <= (a_q[63] != b_q[63]) && (slice_d[7] != a_q[63]);
`endif
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  idx_q <= idx_q + 3'd1;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_subtractor_64bit.sv
// tb/tb_seq_subtractor_64bit.sv - directed and random checks of seq_subtractor_64bit against an arithmetic model
module tb_seq_subtractor_64bit;

   logic        clk;
   logic        rst;
   logic        start;
   logic [63:0] a;
   logic [63:0] b;
   logic        bin;
   logic [63:0] diff;
   logic        bout;
   logic        busy;
   logic        done;
`ifdef SUB_OVERFLOW_EN
   logic        ovf;
`endif

   int passed;
   int total;

   seq_subtractor_64bit dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .bin   (bin),
      .diff  (diff),
      .bout  (bout),
      .busy  (busy),
      .done  (done)
`ifdef SUB_OVERFLOW_EN
      ,
      .ovf   (ovf)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Advance past one rising edge; outputs are then sampled 1 time unit later
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: 65-bit subtraction gives the modulo result and the borrow in bit 64
   task automatic model(input logic [63:0] ma, input logic [63:0] mb, input logic mbin,
                        output logic [63:0] ed, output logic eb, output logic eo);
      logic [64:0] r;
      r  = {1'b0, ma} - {1'b0, mb} - {64'd0, mbin};
      ed = r[63:0];
      eb = r[64];
      eo = (ma[63] != mb[63]) && (r[63] != ma[63]);
   endtask

   // One operation; optionally a second start at edge N+3; inputs are scrambled after acceptance
   task automatic run_op(input string tag, input logic [63:0] oa, input logic [63:0] ob,
                         input logic obin, input bit restart_mid);
      logic [63:0] ed;
      logic        eb;
      logic        eo;
      model(oa, ob, obin, ed, eb, eo);
      a     = oa;
      b     = ob;
      bin   = obin;
      start = 1'b1;
      tick();
      start = 1'b0;
      a     = {$urandom, $urandom};
      b     = {$urandom, $urandom};
      bin   = 1'($urandom);
      for (int k = 0; k < 8; k++) begin
         check({tag, ".busy"}, {63'd0, busy}, 64'd1);
         check({tag, ".done_low"}, {63'd0, done}, 64'd0);
         if (restart_mid && k == 2) begin
            start = 1'b1;
            a     = 64'd9;
            b     = 64'd9;
         end
         tick();
         start = 1'b0;
      end
      check({tag, ".done"}, {63'd0, done}, 64'd1);
      check({tag, ".busy_done"}, {63'd0, busy}, 64'd0);
      check({tag, ".diff"}, diff, ed);
      check({tag, ".bout"}, {63'd0, bout}, {63'd0, eb});
`ifdef SUB_OVERFLOW_EN
      check({tag, ".ovf"}, {63'd0, ovf}, {63'd0, eo});
`endif
      tick();
      check({tag, ".done_pulse"}, {63'd0, done}, 64'd0);
      check({tag, ".diff_hold"}, diff, ed);
   endtask

   initial begin
      logic [63:0] ra;
      logic [63:0] rb;
      logic        rbin;
      passed = 0;
      total  = 0;
      rst    = 1'b1;
      start  = 1'b0;
      a      = 64'd0;
      b      = 64'd0;
      bin    = 1'b0;
      tick();
      start  = 1'b1;
      a      = 64'd7;
      tick();
      start  = 1'b0;
      check("reset.busy", {63'd0, busy}, 64'd0);
      check("reset.done", {63'd0, done}, 64'd0);
      check("reset.diff", diff, 64'd0);
      check("reset.bout", {63'd0, bout}, 64'd0);
`ifdef SUB_OVERFLOW_EN
      check("reset.ovf", {63'd0, ovf}, 64'd0);
`endif
      rst = 1'b0;

      run_op("basic", 64'd5, 64'd3, 1'b0, 1'b0);
      run_op("borrow_all", 64'd0, 64'd1, 1'b0, 1'b0);
      run_op("bin_only", 64'd0, 64'd0, 1'b1, 1'b0);
      run_op("bin_0x100", 64'h100, 64'd0, 1'b1, 1'b0);
      run_op("max_b_bin", 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
      run_op("ovf_pos", 64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b0);
      run_op("ovf_neg", 64'd1, 64'd2, 1'b0, 1'b0);
      run_op("restart_ignored", 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b1);
      check("idle_after_restart", {63'd0, busy}, 64'd0);

      // Reset sampled at edge N+4 aborts the operation
      a     = 64'd100;
      b     = 64'd1;
      bin   = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 3; k++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort.busy", {63'd0, busy}, 64'd0);
      check("abort.diff", diff, 64'd0);
      check("abort.done", {63'd0, done}, 64'd0);
      check("abort.bout", {63'd0, bout}, 64'd0);
      run_op("after_abort", 64'd100, 64'd1, 1'b0, 1'b0);

      for (int n = 0; n < 20; n++) begin
         ra   = {$urandom, $urandom};
         rb   = {$urandom, $urandom};
         rbin = 1'($urandom);
         if (n % 4 == 1) rb = ra;
         run_op("random", ra, rb, rbin, n % 5 == 3);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
